register_file_mp: RTL and testbench
===================================

// Module: register_file_mp
// PURPOSE
//  Parametrised multi-port register file for the pipelined/superscalar datapath.
//  Adds N read ports, M write ports, same-cycle write->read bypass and a
//  per-register busy scoreboard (set at issue, cleared at writeback) for hazard
//  detection. Sits between decode (reads, issue) and writeback (writes).
// PARAMETERS
//  DATA_W   32  data width per register
//  NREGS    32  number of registers (power of 2); AW = $clog2(NREGS)
//  NRD      2   number of read ports
//  NWR      2   number of write ports
//  ZERO_REG 1   1: register 0 reads 0, ignores writes, never busy
//  BYPASS   1   1: same-cycle write data forwarded to matching reads
// PORTS
//  CLK      in   1            clock, rising edge
//  nRST     in   1            asynchronous active-low reset
//  rsel     in   NRD*AW       read selects, port r at [r*AW +: AW]
//  rdat     out  NRD*DATA_W   read data, port r at [r*DATA_W +: DATA_W]
//  rbusy    out  NRD          1: selected register has pending producer
//  wen      in   NWR          write enables
//  wsel     in   NWR*AW       write selects
//  wdat     in   NWR*DATA_W   write data
//  iss_en   in   1            issue: mark iss_sel busy
//  iss_sel  in   AW           destination of issued instruction
//  flush    in   1            clear all busy bits (pipeline squash)
//  busy_vec out  NREGS        raw scoreboard state
// BEHAVIOUR
//  - Reset (nRST=0, async): all registers 0, all busy bits 0; hence rdat=0,
//    rbusy=0, busy_vec=0 during/after reset. Reset mid-operation discards
//    any in-flight write of that cycle.
//  - Write: at posedge, reg[wsel[w]] <= wdat[w] for each w with wen[w]=1.
//    Multiple ports same address: highest port index wins. ZERO_REG=1 and
//    wsel=0: write dropped.
//  - Read: combinational, 0-cycle latency. rdat[r] = reg[rsel[r]]; if BYPASS=1
//    and some wen[w]&&wsel[w]==rsel[r] (not reg 0 under ZERO_REG), rdat[r] =
//    wdat of highest such w. BYPASS=0: new value visible the cycle after write.
//  - ZERO_REG=1: rdat for rsel=0 is always 0, rbusy always 0.
//  - Scoreboard, per register i, next state in priority order:
//      flush -> 0; iss_en&&iss_sel==i -> 1; any wen[w]&&wsel[w]==i -> 0;
//      else hold. (Issue beats writeback to same reg: new producer owns it.)
//    iss_sel=0 under ZERO_REG: ignored. flush and iss_en together: flush wins,
//    busy stays 0. flush never alters register contents.
//  - rbusy[r] = busy[rsel[r]] & ~(BYPASS & matching write this cycle):
//    a register being written back now is reported ready with forwarded data.
//  - busy_vec reflects registered state only (no bypass term).
// STRUCTURE
//  - cpu_types_pkg: word_t, regbits_t (AW-wide select), REG_ZERO constant.
//  - Sub-module rf_scoreboard (busy bits: issue/writeback/flush, priority as
//    above); storage, write arbitration and bypass muxes stay in top.
//  - Write-port arbitration and bypass select via for-loops over NWR
//    (ascending index so last match wins); no generate-specific port lists.
// TESTING
//  1 Reset: preload regs, pulse nRST low mid-cycle -> rdat=0, busy_vec=0 async.
//  2 Write/read: wen[0], wsel=5, wdat=32'hDEADBEEF -> same cycle rdat(rsel=5)
//    =DEADBEEF (BYPASS=1); next cycle still DEADBEEF with wen=0.
//  3 Dual write same reg: w0:(7,0x11), w1:(7,0x22) -> rdat(7)=0x22 now & after.
//  4 Reg 0: write 0xFFFF to 0, iss_en iss_sel=0 -> rdat(0)=0, busy_vec[0]=0.
//  5 Scoreboard: iss_en sel=9 -> busy_vec[9]=1, rbusy=1; later wen sel=9
//    wdat=0x5 -> rbusy=0 & rdat=0x5 same cycle; busy_vec[9]=0 next cycle.
//    Same cycle iss_en sel=9 + write 9 -> busy_vec[9]=1.
//  6 Flush: busy regs 3,4 set, flush+iss_en sel=6 -> busy_vec=0; data unchanged.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared datapath types for the register file slice: word and register-select
// widths plus the hard-wired zero register index.
package cpu_types_pkg;
    localparam int WORD_W = 32;
    localparam int REG_W  = 5;

    typedef logic [WORD_W-1:0] word_t;
    typedef logic [REG_W-1:0]  regbits_t;

    localparam regbits_t REG_ZERO = '0;
endpackage

// File: rtl/rf_scoreboard.sv
// Per-register busy bits: set at issue, cleared at writeback, wiped by flush.
// Issue outranks a same-cycle writeback because the new producer owns the reg.
module rf_scoreboard
    import cpu_types_pkg::*;
#(
    parameter int NREGS    = 32,
    parameter int NWR      = 2,
    parameter int ZERO_REG = 1,
    localparam int AW      = $clog2(NREGS)
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic [NWR-1:0]    wen,
    input  logic [NWR*AW-1:0] wsel,
    input  logic              iss_en,
    input  logic [AW-1:0]     iss_sel,
    input  logic              flush,
    output logic [NREGS-1:0]  busy_vec
);
    logic [NREGS-1:0] busy_next;

    genvar gi;
    generate
        for (gi = 0; gi < NREGS; gi++) begin : g_bit
            logic wr_hit;
            logic is_zero;

            assign is_zero = (ZERO_REG != 0) && (AW'(gi) == AW'(REG_ZERO));

            always_comb begin
                wr_hit = 1'b0;
                for (int w = 0; w < NWR; w++) begin
                    if (wen[w] && (wsel[w*AW +: AW] == AW'(gi)))
                        wr_hit = 1'b1;
                end
            end

            always_comb begin
                busy_next[gi] = busy_vec[gi];
                if (flush || is_zero)
                    busy_next[gi] = 1'b0;
                else if (iss_en && (iss_sel == AW'(gi)))
                    busy_next[gi] = 1'b1;
                else if (wr_hit)
                    busy_next[gi] = 1'b0;
            end

            always_ff @(posedge CLK, negedge nRST) begin
                if (!nRST)
                    busy_vec[gi] <= 1'b0;
                else
                    busy_vec[gi] <= busy_next[gi];
            end
        end
    endgenerate
endmodule

// File: rtl/register_file_mp.sv
// Multi-port register file with same-cycle write->read forwarding and a busy
// scoreboard for hazard detection between decode/issue and writeback.
module register_file_mp
    import cpu_types_pkg::*;
#(
    parameter int DATA_W   = WORD_W,
    parameter int NREGS    = 32,
    parameter int NRD      = 2,
    parameter int NWR      = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1,
    localparam int AW      = $clog2(NREGS)
) (
    input  logic                  CLK,
    input  logic                  nRST,
    input  logic [NRD*AW-1:0]     rsel,
    output logic [NRD*DATA_W-1:0] rdat,
    output logic [NRD-1:0]        rbusy,
    input  logic [NWR-1:0]        wen,
    input  logic [NWR*AW-1:0]     wsel,
    input  logic [NWR*DATA_W-1:0] wdat,
    input  logic                  iss_en,
    input  logic [AW-1:0]         iss_sel,
    input  logic                  flush,
    output logic [NREGS-1:0]      busy_vec
);
    logic [DATA_W-1:0] regs [NREGS];

    // Ascending port order means the highest-index writer to an address wins.
    always_ff @(posedge CLK, negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < NREGS; i++)
                regs[i] <= '0;
        end else begin
            for (int w = 0; w < NWR; w++) begin
                if (wen[w] && !((ZERO_REG != 0) && (wsel[w*AW +: AW] == AW'(REG_ZERO))))
                    regs[wsel[w*AW +: AW]] <= wdat[w*DATA_W +: DATA_W];
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NRD; gi++) begin : g_rd
            logic [AW-1:0]     rs;
            logic              fwd_hit;
            logic [DATA_W-1:0] fwd_val;

            assign rs = rsel[gi*AW +: AW];

            always_comb begin
                fwd_hit = 1'b0;
                fwd_val = regs[rs];
                for (int w = 0; w < NWR; w++) begin
                    if ((BYPASS != 0) && wen[w] && (wsel[w*AW +: AW] == rs)) begin
                        fwd_hit = 1'b1;
                        fwd_val = wdat[w*DATA_W +: DATA_W];
                    end
                end
                if ((ZERO_REG != 0) && (rs == AW'(REG_ZERO))) begin
                    fwd_hit = 1'b0;
                    fwd_val = '0;
                end
            end

            // A register being written back this cycle is ready with forwarded data.
            assign rdat[gi*DATA_W +: DATA_W] = fwd_val;
            assign rbusy[gi]                 = busy_vec[rs] & ~fwd_hit;
        end
    endgenerate

    rf_scoreboard #(
        .NREGS    (NREGS),
        .NWR      (NWR),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .CLK      (CLK),
        .nRST     (nRST),
        .wen      (wen),
        .wsel     (wsel),
        .iss_en   (iss_en),
        .iss_sel  (iss_sel),
        .flush    (flush),
        .busy_vec (busy_vec)
    );
endmodule

// File: tb/tb_register_file_mp.sv
// Directed bench for register_file_mp: stimulus queues expected outputs, a
// negedge monitor pops and compares them against the live DUT outputs.
module tb_register_file_mp;
    import cpu_types_pkg::*;

    localparam int AW  = 5;
    localparam int NRD = 2;
    localparam int NWR = 2;

    logic             CLK;
    logic             nRST;
    logic [NRD*AW-1:0] rsel;
    logic [NRD*32-1:0] rdat;
    logic [NRD-1:0]    rbusy;
    logic [NWR-1:0]    wen;
    logic [NWR*AW-1:0] wsel;
    logic [NWR*32-1:0] wdat;
    logic              iss_en;
    logic [AW-1:0]     iss_sel;
    logic              flush;
    logic [31:0]       busy_vec;

    register_file_mp dut (
        .CLK      (CLK),
        .nRST     (nRST),
        .rsel     (rsel),
        .rdat     (rdat),
        .rbusy    (rbusy),
        .wen      (wen),
        .wsel     (wsel),
        .wdat     (wdat),
        .iss_en   (iss_en),
        .iss_sel  (iss_sel),
        .flush    (flush),
        .busy_vec (busy_vec)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        string name;
        int    kind;   // 0: rdat port, 1: rbusy port, 2: busy_vec
        int    idx;
        word_t val;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;

    task automatic exp_rd(input string name, input int port, input word_t v);
        exp_q.push_back('{name, 0, port, v});
    endtask
    task automatic exp_rb(input string name, input int port, input word_t v);
        exp_q.push_back('{name, 1, port, v});
    endtask
    task automatic exp_bv(input string name, input word_t v);
        exp_q.push_back('{name, 2, 0, v});
    endtask

    always @(negedge CLK) begin
        while (exp_q.size() > 0) begin
            exp_t  e;
            word_t act;
            e = exp_q.pop_front();
            case (e.kind)
                0:       act = rdat[e.idx*32 +: 32];
                1:       act = {31'd0, rbusy[e.idx]};
                default: act = busy_vec;
            endcase
            tests++;
            if (act !== e.val) begin
                fails++;
                $display("[TB] FAIL %s: got %08h expected %08h", e.name, act, e.val);
            end else begin
                $display("[TB] ok   %s: %08h", e.name, act);
            end
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        wen = '0; wsel = '0; wdat = '0;
        iss_en = 1'b0; iss_sel = '0; flush = 1'b0;
    endtask

    task automatic set_rd(input int port, input int sel);
        rsel[port*AW +: AW] = AW'(sel);
    endtask

    task automatic set_wr(input int port, input int sel, input word_t d);
        wen[port]            = 1'b1;
        wsel[port*AW +: AW]  = AW'(sel);
        wdat[port*32 +: 32]  = d;
    endtask

    initial begin
        nRST = 1'b0;
        rsel = '0;
        idle();

        // Reset held from time zero
        step();
        set_rd(0, 5); set_rd(1, 6);
        exp_rd("reset_rd0", 0, 32'h0); exp_rd("reset_rd1", 1, 32'h0); exp_bv("reset_busy", 32'h0);
        step();
        nRST = 1'b1;

        // Preload regs 5/6 and mark reg 2 busy
        set_wr(0, 5, 32'hAAAA_0001); set_wr(1, 6, 32'h0000_0066);
        iss_en = 1'b1; iss_sel = 5'd2;
        exp_rd("preload_byp", 0, 32'hAAAA_0001);
        step();
        idle();
        exp_rd("preload_r5", 0, 32'hAAAA_0001); exp_rd("preload_r6", 1, 32'h0000_0066);
        exp_bv("preload_busy", 32'h0000_0004);
        step();

        // Mid-cycle async reset, then a write held under reset must be lost
        nRST = 1'b0;
        exp_rd("async_rd0", 0, 32'h0); exp_rd("async_rd1", 1, 32'h0); exp_bv("async_busy", 32'h0);
        step();
        set_wr(0, 5, 32'h0000_0077);
        step();
        idle();
        nRST = 1'b1;
        exp_rd("reset_drop_wr", 0, 32'h0);
        step();

        // Write/read with bypass
        set_wr(0, 5, 32'hDEAD_BEEF);
        exp_rd("wr_bypass", 0, 32'hDEAD_BEEF);
        step();
        idle();
        exp_rd("wr_after", 0, 32'hDEAD_BEEF);
        step();

        // Dual write same register: port 1 wins
        set_rd(1, 7);
        set_wr(0, 7, 32'h11); set_wr(1, 7, 32'h22);
        exp_rd("dual_bypass", 1, 32'h22);
        step();
        idle();
        exp_rd("dual_after", 1, 32'h22);
        step();

        // Register zero
        set_rd(0, 0);
        set_wr(0, 0, 32'h0000_FFFF);
        iss_en = 1'b1; iss_sel = 5'd0;
        exp_rd("r0_bypass", 0, 32'h0); exp_rb("r0_rbusy", 0, 32'h0);
        step();
        idle();
        exp_rd("r0_after", 0, 32'h0); exp_bv("r0_busy", 32'h0);
        step();

        // Scoreboard issue -> writeback
        iss_en = 1'b1; iss_sel = 5'd9;
        step();
        idle();
        set_rd(0, 9);
        exp_bv("sb_issue", 32'h0000_0200); exp_rb("sb_rbusy", 0, 32'h1);
        step();
        set_wr(0, 9, 32'h5);
        exp_rd("sb_wb_data", 0, 32'h5); exp_rb("sb_wb_rbusy", 0, 32'h0);
        exp_bv("sb_wb_raw", 32'h0000_0200);
        step();
        idle();
        exp_bv("sb_cleared", 32'h0); exp_rd("sb_wb_hold", 0, 32'h5);
        step();
        iss_en = 1'b1; iss_sel = 5'd9;
        set_wr(1, 9, 32'h6);
        exp_rd("sb_iss_wb_data", 0, 32'h6); exp_rb("sb_iss_wb_rbusy", 0, 32'h0);
        step();
        idle();
        exp_bv("sb_iss_wins", 32'h0000_0200); exp_rb("sb_iss_wins_rb", 0, 32'h1);
        exp_rd("sb_iss_wins_data", 0, 32'h6);
        step();

        // Flush together with issue
        iss_en = 1'b1; iss_sel = 5'd3;
        step();
        iss_sel = 5'd4;
        step();
        idle();
        set_rd(0, 3);
        flush = 1'b1; iss_en = 1'b1; iss_sel = 5'd6;
        exp_bv("flush_before", 32'h0000_0218); exp_rb("flush_rb3", 0, 32'h1);
        step();
        idle();
        set_rd(0, 5);
        exp_bv("flush_after", 32'h0); exp_rb("flush_rb_clear", 0, 32'h0);
        exp_rd("flush_r5", 0, 32'hDEAD_BEEF); exp_rd("flush_r7", 1, 32'h22);
        step();

        for (int i = 0; i < 10 && exp_q.size() > 0; i++)
            step();
        if (exp_q.size() != 0) begin
            fails++;
            $display("[TB] FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
